// File: rtl/control_execute_stage.sv
// ID->EX pipeline register with slow-FPU occupancy tracking and I/O hazard stall.
// Ports: clk, rstn (async low); id_valid/id_ctrl in; flush, ex_stall, in_valid,
//   out_ready in; ex_valid/ex_ctrl, id_stall, slow_fpu_busy, slow_fpu_done out.
//   Define CTRL_STAGE_PERF_EN to add perf_stall_cycles / perf_bubbles counters.

package control_execute_pkg;

    // The named fields fill all 24 bits, so funct3_0 sits at bit 0.
    typedef struct packed {
        logic       branch;
        logic       jump;
        logic [2:0] result_src;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [4:0] alu_control;
        logic       out_issued;
        logic       in_issued;
        logic       fast_fpu_dispatch;
        logic       slow_fpu_dispatch;
        logic       fpu_reg_write;
        logic [1:0] write_src;
        logic       s_fpu;
        logic       alu_op_and;
        logic       funct3_0;
    } ex_ctrl_t;

endpackage

module control_execute_stage
    import control_execute_pkg::*;
#(
    parameter int unsigned SLOW_FPU_LAT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [23:0] id_ctrl,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        ex_valid,
    output logic [23:0] ex_ctrl,
    output logic        id_stall,
    output logic        slow_fpu_busy,
    output logic        slow_fpu_done
`ifdef CTRL_STAGE_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_bubbles
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(SLOW_FPU_LAT - 1);

    ex_ctrl_t   id_c;
    ex_ctrl_t   ex_c;
    ex_ctrl_t   bubble_c;
    logic [1:0] state;
    logic [3:0] cnt;

    logic io_hazard;
    logic slow_hazard;
    logic hold;
    logic load;
    logic bubble;
    logic slow_start;

    assign id_c = id_ctrl;

    // A bubble keeps the datapath fields but drops every side effect.
    always_comb begin
        bubble_c                   = id_c;
        bubble_c.branch            = 1'b0;
        bubble_c.jump              = 1'b0;
        bubble_c.mem_read          = 1'b0;
        bubble_c.mem_write         = 1'b0;
        bubble_c.reg_write         = 1'b0;
        bubble_c.out_issued        = 1'b0;
        bubble_c.in_issued         = 1'b0;
        bubble_c.fast_fpu_dispatch = 1'b0;
        bubble_c.slow_fpu_dispatch = 1'b0;
        bubble_c.fpu_reg_write     = 1'b0;
    end

    assign io_hazard = ex_valid &
                       ((ex_c.in_issued & ~in_valid) |
                        (ex_c.out_issued & ~out_ready));

    // A flushed slow dispatch is dropped, so it need not wait for the FPU.
    assign slow_hazard = id_valid & id_c.slow_fpu_dispatch &
                         (state == S_BUSY) & ~flush;

    assign id_stall   = io_hazard | slow_hazard;

    // An EX instruction waiting on an I/O handshake must not be overwritten.
    assign hold       = ex_stall | io_hazard;
    assign load       = id_valid & ~id_stall & ~hold & ~flush;
    assign bubble     = ~hold & ~load;
    assign slow_start = load & id_c.slow_fpu_dispatch;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid <= 1'b0;
            ex_c     <= '0;
        end else if (!hold) begin
            ex_valid <= load;
            ex_c     <= load ? id_c : bubble_c;
        end
    end

    assign ex_ctrl = ex_c;

    // BUSY lasts SLOW_FPU_LAT-1 cycles and DONE one more, so the unit is
    // occupied SLOW_FPU_LAT cycles; the counter reaches 0 on entry to DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (slow_start) begin
                        state <= S_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (slow_start) begin
                        state <= S_BUSY;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign slow_fpu_busy = (state == S_BUSY);
    assign slow_fpu_done = (state == S_DONE);

`ifdef CTRL_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cycles <= 32'd0;
            perf_bubbles      <= 32'd0;
        end else begin
            if (id_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bubble) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_control_execute_stage.sv
// Self-checking bench for control_execute_stage: directed scenarios then
// random traffic, all compared against a cycle-level reference model.

module tb_control_execute_stage;

    localparam int LAT = 4;

    localparam int B_SLOW = 6;
    localparam int B_IN   = 8;
    localparam int B_OUT  = 9;
    localparam int B_MW   = 17;

    // branch, jump, mem_read, mem_write, reg_write, out/in_issued,
    // fast/slow dispatch, fpu_reg_write
    localparam logic [23:0] KILL = 24'hC683E0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic [23:0] id_ctrl;
    logic        flush;
    logic        ex_stall;
    logic        in_valid;
    logic        out_ready;
    logic        ex_valid;
    logic [23:0] ex_ctrl;
    logic        id_stall;
    logic        slow_fpu_busy;
    logic        slow_fpu_done;
`ifdef CTRL_STAGE_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_bubbles;
`endif

    control_execute_stage #(.SLOW_FPU_LAT(LAT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .id_stall     (id_stall),
        .slow_fpu_busy(slow_fpu_busy),
        .slow_fpu_done(slow_fpu_done)
`ifdef CTRL_STAGE_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_bubbles     (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: EX contents, remaining FPU occupancy (incl. done cycle)
    logic        m_valid;
    logic [23:0] m_ctrl;
    int          fpu_left;
    int unsigned m_stalls;
    int unsigned m_bubbles;

    logic [23:0] cx;
    logic [23:0] cy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_io();
        return m_valid && ((m_ctrl[B_IN] && !in_valid) ||
                           (m_ctrl[B_OUT] && !out_ready));
    endfunction

    function automatic logic m_stall();
        return m_io() ||
               (id_valid && id_ctrl[B_SLOW] && fpu_left > 1 && !flush);
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_ctrl    = 24'h0;
        fpu_left  = 0;
        m_stalls  = 0;
        m_bubbles = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        if (!rstn) model_reset();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("busy", 32'(slow_fpu_busy), 32'(fpu_left > 1));
        chk("done", 32'(slow_fpu_done), 32'(fpu_left == 1));
        chk("id_stall", 32'(id_stall), 32'(m_stall()));
`ifdef CTRL_STAGE_PERF_EN
        chk("perf_stall", perf_stall_cycles, m_stalls);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    endtask

    task automatic adv();
        logic st;
        logic io;
        logic start;
        @(posedge clk);
        if (rstn) begin
            st    = m_stall();
            io    = m_io();
            start = 1'b0;
            if (st) m_stalls++;
            if (!(ex_stall || io)) begin
                if (id_valid && !st && !flush) begin
                    m_valid = 1'b1;
                    m_ctrl  = id_ctrl;
                    start   = id_ctrl[B_SLOW];
                end else begin
                    m_valid = 1'b0;
                    m_ctrl  = id_ctrl & ~KILL;
                    m_bubbles++;
                end
            end
            if (start) fpu_left = LAT;
            else if (fpu_left > 0) fpu_left--;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        id_ctrl   = 24'h0;
        flush     = 1'b0;
        ex_stall  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        sample();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        adv();
        sample();
        adv();
        rstn = 1'b1;
        sample();
        adv();

        // reg_write with alu_control 3 lands in EX one cycle later
        cx       = 24'h008C00;
        id_valid = 1'b1;
        id_ctrl  = cx;
        sample();
        adv();
        idle_inputs();
        sample();
        chk("basic_valid", 32'(ex_valid), 32'd1);
        chk("basic_ctrl", 32'(ex_ctrl), 32'(cx));
        adv();

        // back-to-back slow dispatches
        id_valid = 1'b1;
        id_ctrl  = 24'h000060;
        sample();
        chk("slow_c0_stall", 32'(id_stall), 32'd0);
        adv();
        id_ctrl = 24'h000061;
        for (int c = 1; c <= 3; c++) begin
            sample();
            chk("slow_c123_stall", 32'(id_stall), 32'd1);
            chk("slow_c123_busy", 32'(slow_fpu_busy), 32'd1);
            adv();
        end
        sample();
        chk("slow_c4_done", 32'(slow_fpu_done), 32'd1);
        chk("slow_c4_stall", 32'(id_stall), 32'd0);
        adv();
        idle_inputs();
        sample();
        chk("slow_2nd_ctrl", 32'(ex_ctrl), 32'h000061);
        chk("slow_2nd_busy", 32'(slow_fpu_busy), 32'd1);
        adv();
        repeat (6) begin
            sample();
            adv();
        end

        // flush turns a store into a bubble
        id_valid = 1'b1;
        id_ctrl  = 24'h028000;
        flush    = 1'b1;
        sample();
        adv();
        idle_inputs();
        sample();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_mw", 32'(ex_ctrl[B_MW]), 32'd0);
        adv();

        // ex_stall holds EX for 3 cycles, flush in the middle has no effect
        cx       = 24'h028C05;
        cy       = 24'h00A413;
        id_valid = 1'b1;
        id_ctrl  = cx;
        sample();
        adv();
        id_ctrl  = cy;
        ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            sample();
            chk("hold_ctrl", 32'(ex_ctrl), 32'(cx));
            adv();
        end
        ex_stall = 1'b0;
        flush    = 1'b0;
        sample();
        chk("hold_after", 32'(ex_ctrl), 32'(cx));
        adv();

        // input-port wait holds EX and stalls ID for 5 cycles
        cx       = 24'h008100;
        cy       = 24'h009800;
        id_ctrl  = cx;
        sample();
        adv();
        id_ctrl  = cy;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("in_wait_stall", 32'(id_stall), 32'd1);
            chk("in_wait_ctrl", 32'(ex_ctrl), 32'(cx));
            adv();
        end
        in_valid = 1'b1;
        sample();
        chk("in_release", 32'(id_stall), 32'd0);
        adv();
        idle_inputs();
        sample();
        chk("in_next_ctrl", 32'(ex_ctrl), 32'(cy));
        adv();

        // reset while the slow FPU is busy
        id_valid = 1'b1;
        id_ctrl  = 24'h000060;
        sample();
        adv();
        idle_inputs();
        sample();
        chk("mid_busy", 32'(slow_fpu_busy), 32'd1);
        adv();
        #1 rstn = 1'b0;
        sample();
        chk("rst_busy", 32'(slow_fpu_busy), 32'd0);
        chk("rst_done", 32'(slow_fpu_done), 32'd0);
`ifdef CTRL_STAGE_PERF_EN
        chk("rst_perf_stall", perf_stall_cycles, 32'd0);
        chk("rst_perf_bub", perf_bubbles, 32'd0);
`endif
        adv();
        rstn = 1'b1;
        repeat (6) begin
            sample();
            chk("no_done_after_rst", 32'(slow_fpu_done), 32'd0);
            adv();
        end

        // random traffic
        for (int n = 0; n < 500; n++) begin
            id_valid  = ($urandom_range(0, 3) != 0);
            id_ctrl   = 24'($urandom());
            id_ctrl[B_SLOW] = ($urandom_range(0, 4) == 0);
            id_ctrl[B_IN]   = ($urandom_range(0, 3) == 0);
            id_ctrl[B_OUT]  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            ex_stall  = ($urandom_range(0, 6) == 0);
            in_valid  = ($urandom_range(0, 4) < 3);
            out_ready = ($urandom_range(0, 4) < 3);
            sample();
            adv();
        end

        idle_inputs();
        repeat (8) begin
            sample();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
